frame_sequencer: RTL

//  Generates the 512 Hz frame-sequencer timebase that clocks the channel modulation units.

---
 rtl/frame_sequencer.sv | 42 ++++
 1 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: divides clk to the 512 Hz sequencer rate and issues length/sweep/envelope strobes
module frame_sequencer #(
  parameter int DIV_RATIO = 8192,
  parameter int CNT_W     = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_en,
  input  logic       div_reset,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic [2:0] step,
  output logic       len_skip
);
  logic [CNT_W-1:0] r_div_cnt;
  logic [2:0]       r_step;
  logic             r_len, r_sweep, r_env;
  logic             w_tick;
  assign w_tick = apu_en && !div_reset && (r_div_cnt == CNT_W'(DIV_RATIO - 1));
  // strobes decode the step being executed, i.e. the value before the increment
  always_ff @(posedge clk) begin
    if (!rst_n || !apu_en) begin
      r_div_cnt <= '0;
      r_step    <= '0;
      r_len     <= 1'b0;
      r_sweep   <= 1'b0;
      r_env     <= 1'b0;
    end else begin
      r_div_cnt <= (div_reset || w_tick) ? '0 : r_div_cnt + 1'b1;
      r_step    <= w_tick ? r_step + 3'd1 : r_step;
      r_len     <= w_tick && !r_step[0];
      r_sweep   <= w_tick && (r_step[1:0] == 2'b10);
      r_env     <= w_tick && (&r_step);
    end
  end
  assign len_tick   = r_len;
  assign sweep_tick = r_sweep;
  assign env_tick   = r_env;
  assign step       = r_step;
  assign len_skip   = r_step[0];
endmodule
